// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the score keeper.
//   state_t        - score keeper FSM encoding (exported via state_dbg)
//   WINNER_*       - winner output codes
//   ROUND_RST_LEN  - cycles round_rst is held after a normal point
//   sat_inc        - 4-bit increment that saturates at 15
package pong_pkg;

  typedef enum logic [2:0] {
    ST_PLAY      = 3'd0,
    ST_HOLD      = 3'd1,
    ST_ROUND_RST = 3'd2,
    ST_ARM       = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  localparam int ROUND_RST_LEN = 2;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/score_rules.sv
// score_rules: combinational scoring and win decision.
// Ports:
//   i_score_p1/p2 : current scores
//   i_add_p1/p2   : add one point to that player (at most one set at a time)
//   o_next_p1/p2  : scores after the point (saturating, deuce-adjusted)
//   o_win         : the current scores end the match
//   o_winner      : WINNER_NONE / WINNER_P1 / WINNER_P2 for the current scores
// Macro SCORE_KEEPER_DEUCE_EN: when defined, a win also needs a lead of 2,
// and a point that ties the match at WIN_SCORE pulls both back to WIN_SCORE-1.
module score_rules
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = 7
) (
  input  logic [3:0] i_score_p1,
  input  logic [3:0] i_score_p2,
  input  logic       i_add_p1,
  input  logic       i_add_p2,
  output logic [3:0] o_next_p1,
  output logic [3:0] o_next_p2,
  output logic       o_win,
  output logic [1:0] o_winner
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  logic [3:0] w_inc_p1;
  logic [3:0] w_inc_p2;

  always_comb begin
    w_inc_p1 = i_add_p1 ? sat_inc(i_score_p1) : i_score_p1;
    w_inc_p2 = i_add_p2 ? sat_inc(i_score_p2) : i_score_p2;
  end

`ifdef SCORE_KEEPER_DEUCE_EN
  localparam logic [3:0] DEUCE = 4'(WIN_SCORE - 1);

  always_comb begin
    o_next_p1 = w_inc_p1;
    o_next_p2 = w_inc_p2;
    if ((i_add_p1 || i_add_p2) && (w_inc_p1 == WIN) && (w_inc_p2 == WIN)) begin
      o_next_p1 = DEUCE;
      o_next_p2 = DEUCE;
    end
    o_winner = WINNER_NONE;
    // Leads are compared in 5 bits so score+2 cannot wrap.
    if ((i_score_p1 >= WIN) && ({1'b0, i_score_p1} >= {1'b0, i_score_p2} + 5'd2))
      o_winner = WINNER_P1;
    else if ((i_score_p2 >= WIN) && ({1'b0, i_score_p2} >= {1'b0, i_score_p1} + 5'd2))
      o_winner = WINNER_P2;
  end
`else
  always_comb begin
    o_next_p1 = w_inc_p1;
    o_next_p2 = w_inc_p2;
    o_winner  = WINNER_NONE;
    if (i_score_p1 >= WIN)
      o_winner = WINNER_P1;
    else if (i_score_p2 >= WIN)
      o_winner = WINNER_P2;
  end
`endif

  assign o_win = (o_winner != WINNER_NONE);

endmodule

// File: rtl/score_keeper.sv
// score_keeper: Pong match scoring and round sequencing.
// Ports:
//   clk, rst_n            : frame clock, synchronous active-low reset
//   goal_p1, goal_p2      : level goal indications from the playfield
//   new_game              : level match restart request (beats goals)
//   score_p1, score_p2    : 4-bit saturating scores
//   round_rst             : reset for ball/paddle blocks (ROUND_RST and OVER)
//   freeze                : ball move disable while in HOLD
//   serve_dir             : 0 serve toward p1, 1 toward p2 (last conceder)
//   game_over, winner     : match result, registered on entry to OVER
//   state_dbg             : current FSM state
// Macro SCORE_KEEPER_DEUCE_EN enables the win-by-two rule in score_rules.
// Handshake: goals are level signals, consumed only in PLAY; after a point
// the FSM waits in ARM until both goals are low, so a held goal counts once.
// All outputs come straight from registers.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       goal_p1,
  input  logic       goal_p2,
  input  logic       new_game,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       round_rst,
  output logic       freeze,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] winner,
  output state_t     state_dbg
);

  localparam logic [9:0] HOLD_LOAD = 10'(SERVE_DELAY - 1);
  localparam logic [9:0] RR_LOAD   = 10'(ROUND_RST_LEN - 1);

  state_t     r_state, w_state_nxt;
  logic [9:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_score_p1, w_score_p1_nxt;
  logic [3:0] r_score_p2, w_score_p2_nxt;
  logic       r_serve_dir, w_serve_dir_nxt;
  logic       r_game_over, w_game_over_nxt;
  logic [1:0] r_winner, w_winner_nxt;
  logic       r_freeze, w_freeze_nxt;
  logic       r_round_rst, w_round_rst_nxt;

  logic       w_add_p1;
  logic       w_add_p2;
  logic [3:0] w_rule_p1;
  logic [3:0] w_rule_p2;
  logic       w_rule_win;
  logic [1:0] w_rule_winner;

  // A simultaneous double goal scores for nobody.
  assign w_add_p1 = goal_p1 & ~goal_p2;
  assign w_add_p2 = goal_p2 & ~goal_p1;

  score_rules #(
    .WIN_SCORE (WIN_SCORE)
  ) u_rules (
    .i_score_p1 (r_score_p1),
    .i_score_p2 (r_score_p2),
    .i_add_p1   (w_add_p1),
    .i_add_p2   (w_add_p2),
    .o_next_p1  (w_rule_p1),
    .o_next_p2  (w_rule_p2),
    .o_win      (w_rule_win),
    .o_winner   (w_rule_winner)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_score_p1_nxt  = r_score_p1;
    w_score_p2_nxt  = r_score_p2;
    w_serve_dir_nxt = r_serve_dir;
    w_game_over_nxt = r_game_over;
    w_winner_nxt    = r_winner;

    if (new_game) begin
      w_state_nxt     = ST_ROUND_RST;
      w_cnt_nxt       = RR_LOAD;
      w_score_p1_nxt  = 4'd0;
      w_score_p2_nxt  = 4'd0;
      w_serve_dir_nxt = 1'b0;
      w_game_over_nxt = 1'b0;
      w_winner_nxt    = WINNER_NONE;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (goal_p1 || goal_p2) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = HOLD_LOAD;
            if (w_add_p1 || w_add_p2) begin
              w_score_p1_nxt  = w_rule_p1;
              w_score_p2_nxt  = w_rule_p2;
              // Serve goes toward whoever conceded.
              w_serve_dir_nxt = w_add_p1;
            end
          end
        end
        ST_HOLD: begin
          if (r_cnt == 10'd0) begin
            if (w_rule_win) begin
              w_state_nxt     = ST_OVER;
              w_game_over_nxt = 1'b1;
              w_winner_nxt    = w_rule_winner;
            end else begin
              w_state_nxt = ST_ROUND_RST;
              w_cnt_nxt   = RR_LOAD;
            end
          end else begin
            w_cnt_nxt = r_cnt - 10'd1;
          end
        end
        ST_ROUND_RST: begin
          if (r_cnt == 10'd0)
            w_state_nxt = ST_ARM;
          else
            w_cnt_nxt = r_cnt - 10'd1;
        end
        ST_ARM: begin
          if (!goal_p1 && !goal_p2)
            w_state_nxt = ST_PLAY;
        end
        ST_OVER: begin
          w_state_nxt = ST_OVER;
        end
        default: begin
          w_state_nxt = ST_ROUND_RST;
          w_cnt_nxt   = RR_LOAD;
        end
      endcase
    end

    // Status flags are registered from the next state so they line up
    // with the state register.
    w_freeze_nxt    = (w_state_nxt == ST_HOLD);
    w_round_rst_nxt = (w_state_nxt == ST_ROUND_RST) || (w_state_nxt == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_ROUND_RST;
      r_cnt       <= RR_LOAD;
      r_score_p1  <= 4'd0;
      r_score_p2  <= 4'd0;
      r_serve_dir <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= WINNER_NONE;
      r_freeze    <= 1'b0;
      r_round_rst <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_score_p1  <= w_score_p1_nxt;
      r_score_p2  <= w_score_p2_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_game_over <= w_game_over_nxt;
      r_winner    <= w_winner_nxt;
      r_freeze    <= w_freeze_nxt;
      r_round_rst <= w_round_rst_nxt;
    end
  end

  assign score_p1  = r_score_p1;
  assign score_p2  = r_score_p2;
  assign round_rst = r_round_rst;
  assign freeze    = r_freeze;
  assign serve_dir = r_serve_dir;
  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: self-checking bench for score_keeper.
// Point records (goal pattern, goal hold length, expected scores/serve/result)
// are played in order; the expected result of each point is queued when the
// goal is driven and compared when HOLD ends. Hand-written sequences cover
// OVER, new_game and reset in mid-HOLD. Honours SCORE_KEEPER_DEUCE_EN.
module tb_score_keeper;
  import pong_pkg::*;

  localparam int WIN_SCORE   = 7;
  localparam int SERVE_DELAY = 120;
  localparam int RR_LEN      = 2;
  localparam int SB_W        = 12;

  logic       clk;
  logic       rst_n;
  logic       goal_p1;
  logic       goal_p2;
  logic       new_game;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       round_rst;
  logic       freeze;
  logic       serve_dir;
  logic       game_over;
  logic [1:0] winner;
  state_t     state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       g1;
    logic       g2;
    int         goal_len;
    logic [3:0] p1;
    logic [3:0] p2;
    logic       sd;
    logic       ov;
    logic [1:0] wn;
  } vec_t;

  vec_t            vecs[$];
  logic [SB_W-1:0] exp_q[$];

  score_keeper #(
    .WIN_SCORE   (WIN_SCORE),
    .SERVE_DELAY (SERVE_DELAY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .goal_p1   (goal_p1),
    .goal_p2   (goal_p2),
    .new_game  (new_game),
    .score_p1  (score_p1),
    .score_p2  (score_p2),
    .round_rst (round_rst),
    .freeze    (freeze),
    .serve_dir (serve_dir),
    .game_over (game_over),
    .winner    (winner),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver and checking tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic add_vec(input logic g1, input logic g2, input int len,
                         input int p1, input int p2, input logic sd,
                         input logic ov, input logic [1:0] wn);
    vec_t v;
    v.g1 = g1; v.g2 = g2; v.goal_len = len;
    v.p1 = 4'(p1); v.p2 = 4'(p2); v.sd = sd; v.ov = ov; v.wn = wn;
    vecs.push_back(v);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_score_p1"}, score_p1, 0);
    check({pfx, "_score_p2"}, score_p2, 0);
    check({pfx, "_winner"}, winner, 0);
    check({pfx, "_game_over"}, game_over, 0);
    check({pfx, "_freeze"}, freeze, 0);
    check({pfx, "_serve_dir"}, serve_dir, 0);
    check({pfx, "_round_rst"}, round_rst, 1);
    check({pfx, "_state"}, int'(state_dbg), int'(ST_ROUND_RST));
  endtask

  // Release rst_n and count round_rst-high cycles, including the one
  // already observed after the last reset edge.
  task automatic release_and_count(input string pfx);
    int n;
    rst_n = 1'b1;
    n = 1;
    tick();
    while (round_rst && n < 10) begin
      n++;
      tick();
    end
    check({pfx, "_rr_len"}, n, RR_LEN);
  endtask

  task automatic wait_play();
    int n;
    n = 0;
    while (state_dbg != ST_PLAY && n < 1000) begin
      tick();
      n++;
    end
    check("reach_play", int'(state_dbg), int'(ST_PLAY));
  endtask

  task automatic release_goals(input int cyc, input int len);
    if (cyc >= len) begin
      goal_p1 = 1'b0;
      goal_p2 = 1'b0;
    end
  endtask

  task automatic do_point(input vec_t v, input int idx);
    int              cyc;
    int              frz;
    int              rr;
    int              arm;
    int              exp_arm;
    logic [SB_W-1:0] exp_v;
    logic [SB_W-1:0] act;
    wait_play();
    goal_p1 = v.g1;
    goal_p2 = v.g2;
    exp_q.push_back({v.p1, v.p2, v.sd, v.ov, v.wn});
    cyc = 0; frz = 0; rr = 0; arm = 0;
    tick(); cyc++; release_goals(cyc, v.goal_len);
    check($sformatf("v%0d_hold_entry", idx), int'(state_dbg), int'(ST_HOLD));
    while (freeze && frz < 5000) begin
      frz++;
      tick(); cyc++; release_goals(cyc, v.goal_len);
    end
    check($sformatf("v%0d_hold_len", idx), frz, SERVE_DELAY);
    act   = {score_p1, score_p2, serve_dir, game_over, winner};
    exp_v = exp_q.pop_front();
    check($sformatf("v%0d_result", idx), int'(act), int'(exp_v));
    if (!v.ov) begin
      while (round_rst && rr < 10) begin
        rr++;
        tick(); cyc++; release_goals(cyc, v.goal_len);
      end
      check($sformatf("v%0d_rr_len", idx), rr, RR_LEN);
      while (state_dbg == ST_ARM && arm < 5000) begin
        arm++;
        tick(); cyc++; release_goals(cyc, v.goal_len);
      end
      // A goal still held at ARM keeps the FSM there until it drops.
      exp_arm = (v.goal_len > SERVE_DELAY + RR_LEN) ? v.goal_len - (SERVE_DELAY + RR_LEN) : 1;
      check($sformatf("v%0d_arm_len", idx), arm, exp_arm);
    end else begin
      goal_p1 = 1'b0;
      goal_p2 = 1'b0;
    end
  endtask

  // main sequence
  initial begin
    int split_a;
    int split_b;
    vec_t last;

    rst_n    = 1'b0;
    goal_p1  = 1'b0;
    goal_p2  = 1'b0;
    new_game = 1'b0;

    // Match 1: single goal, long-held goal, double goal, then to a win.
    add_vec(1, 0, 10,  1, 0, 1, 0, WINNER_NONE);
    add_vec(0, 1, 200, 1, 1, 0, 0, WINNER_NONE);
    add_vec(1, 1, 10,  1, 1, 0, 0, WINNER_NONE);
    add_vec(0, 1, 3,   1, 2, 0, 0, WINNER_NONE);
`ifdef SCORE_KEEPER_DEUCE_EN
    add_vec(1, 0, 4, 2, 2, 1, 0, WINNER_NONE);
    add_vec(1, 0, 4, 3, 2, 1, 0, WINNER_NONE);
    add_vec(0, 1, 4, 3, 3, 0, 0, WINNER_NONE);
    add_vec(1, 0, 4, 4, 3, 1, 0, WINNER_NONE);
    add_vec(0, 1, 4, 4, 4, 0, 0, WINNER_NONE);
    add_vec(1, 0, 4, 5, 4, 1, 0, WINNER_NONE);
    add_vec(0, 1, 4, 5, 5, 0, 0, WINNER_NONE);
    add_vec(1, 0, 4, 6, 5, 1, 0, WINNER_NONE);
    add_vec(0, 1, 4, 6, 6, 0, 0, WINNER_NONE);
    add_vec(1, 0, 4, 7, 6, 1, 0, WINNER_NONE);
    add_vec(0, 1, 4, 6, 6, 0, 0, WINNER_NONE);
    add_vec(1, 0, 4, 7, 6, 1, 0, WINNER_NONE);
    add_vec(1, 0, 4, 8, 6, 1, 1, WINNER_P1);
`else
    add_vec(1, 0, 4, 2, 2, 1, 0, WINNER_NONE);
    add_vec(1, 0, 4, 3, 2, 1, 0, WINNER_NONE);
    add_vec(1, 0, 4, 4, 2, 1, 0, WINNER_NONE);
    add_vec(1, 0, 4, 5, 2, 1, 0, WINNER_NONE);
    add_vec(1, 0, 4, 6, 2, 1, 0, WINNER_NONE);
    add_vec(1, 0, 4, 7, 2, 1, 1, WINNER_P1);
`endif
    split_a = vecs.size();
    // Match 2: reach 3-1 before the mid-HOLD reset.
    add_vec(1, 0, $urandom_range(1, 20), 1, 0, 1, 0, WINNER_NONE);
    add_vec(1, 0, $urandom_range(1, 20), 2, 0, 1, 0, WINNER_NONE);
    add_vec(0, 1, $urandom_range(1, 20), 2, 1, 0, 0, WINNER_NONE);
    add_vec(1, 0, $urandom_range(1, 20), 3, 1, 1, 0, WINNER_NONE);
    split_b = vecs.size();
    // After the reset the score must restart from 0-0.
    add_vec(0, 1, 5, 0, 1, 0, 0, WINNER_NONE);

    // reset
    tick(); tick();
    check_reset("rst");
    release_and_count("rst");

    for (int i = 0; i < split_a; i++) do_point(vecs[i], i);

    // OVER: goals ignored, outputs held
    last = vecs[split_a - 1];
    goal_p2 = 1'b1;
    repeat (5) tick();
    check("over_state", int'(state_dbg), int'(ST_OVER));
    check("over_score_p1", score_p1, last.p1);
    check("over_score_p2", score_p2, last.p2);
    check("over_game_over", game_over, 1);
    check("over_winner", winner, WINNER_P1);
    check("over_round_rst", round_rst, 1);
    check("over_freeze", freeze, 0);

    // new_game wins over a held goal
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    goal_p2  = 1'b0;
    check_reset("newgame");

    for (int i = split_a; i < split_b; i++) do_point(vecs[i], i);

    // reset in mid-HOLD at 3-2
    wait_play();
    goal_p2 = 1'b1;
    tick();
    check("midhold_score_p1", score_p1, 3);
    check("midhold_score_p2", score_p2, 2);
    check("midhold_freeze", freeze, 1);
    repeat (50) tick();
    check("midhold_still_frozen", freeze, 1);
    rst_n   = 1'b0;
    goal_p2 = 1'b0;
    tick();
    check_reset("midhold_rst");
    release_and_count("midhold_rst");

    do_point(vecs[split_b], split_b);

    // new_game beats a goal in PLAY
    wait_play();
    goal_p1  = 1'b1;
    new_game = 1'b1;
    tick();
    goal_p1  = 1'b0;
    new_game = 1'b0;
    check_reset("ng_prio");

    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, meaning the points needed to win; legal range is 1..15, or 1..14 with the deuce rule.
REQ-002 SHALL have parameter SERVE_DELAY, default 120, meaning the clk cycles (frames) of HOLD after a goal; legal range is 1..1023.
REQ-003 SHALL have port clk, input, 1 bit: the frame-rate clock, driven from frame_tick as the game blocks are.
REQ-004 SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port goal_p1, input, 1 bit: level, high while player 1 has scored, held until the round reset.
REQ-006 SHALL have port goal_p2, input, 1 bit: level, high while player 2 has scored.
REQ-007 SHALL have port new_game, input, 1 bit: level, high requests a match restart.
REQ-008 SHALL have port score_p1, output, 4 bits: player 1 points.
REQ-009 SHALL have port score_p2, output, 4 bits: player 2 points.
REQ-010 SHALL have port round_rst, output, 1 bit: drives the rst of the ball/paddle/direction blocks.
REQ-011 SHALL have port freeze, output, 1 bit: high during HOLD; the ball move enable is deasserted.
REQ-012 SHALL have port serve_dir, output, 1 bit: 0 serves toward p1, 1 serves toward p2, i.e. toward the player who conceded the last point.
REQ-013 SHALL have port game_over, output, 1 bit.
REQ-014 SHALL have port winner, output, 2 bits: 00 none, 01 p1, 10 p2.

Function
REQ-015 SHALL implement the FSM states PLAY, HOLD, ROUND_RST, ARM and OVER.
REQ-016 In PLAY, when exactly one goal input is high, SHALL add 1 to that player's score in the same edge, load the hold counter with SERVE_DELAY-1, set serve_dir toward the conceding player, and go to HOLD.
REQ-017 In PLAY, when goal_p1 and goal_p2 are high in the same cycle, SHALL leave both scores unchanged and serve_dir unchanged, and go to HOLD.
REQ-018 SHALL ignore goal inputs in every state except PLAY, so each goal is counted exactly once.
REQ-019 In HOLD, SHALL hold freeze=1 and decrement the counter each cycle; at count 0, SHALL go to ROUND_RST, or to OVER if the win condition is met.
REQ-020 In ROUND_RST, SHALL hold round_rst=1 for exactly 2 cycles, then go to ARM.
REQ-021 In ARM, SHALL keep round_rst=0 and go to PLAY on the first cycle in which both goal inputs are low.
REQ-022 The win condition without deuce SHALL be score ≥ WIN_SCORE; winner and game_over SHALL be registered on entry to OVER.
REQ-023 In OVER, SHALL hold round_rst=1, keep the scores frozen, and hold game_over=1.
REQ-024 new_game=1 in any state SHALL, on the next edge, clear the scores, winner and game_over, set serve_dir=0, and go to ROUND_RST; new_game SHALL have priority over goals.
REQ-025 Scores SHALL saturate at 15 and never wrap.
REQ-026 All outputs SHALL be registered, with no combinational input-to-output paths.

Reset
REQ-027 When rst_n=0 at a clk edge, SHALL set scores=0, winner=00, game_over=0, freeze=0, serve_dir=0, round_rst=1, and state=ROUND_RST with a full 2-cycle count.
REQ-028 Reset in mid-HOLD or mid-OVER SHALL discard the pending point, state and counter.

Configuration
REQ-029 Macro SCORE_KEEPER_DEUCE_EN, when defined, SHALL make the win condition score ≥ WIN_SCORE and a lead ≥ 2.
REQ-030 With SCORE_KEEPER_DEUCE_EN defined, a scored point that produces a tie at WIN_SCORE SHALL set both scores to WIN_SCORE-1 on that same edge.
REQ-031 With SCORE_KEEPER_DEUCE_EN undefined, SHALL synthesize no lead-compare or tie logic and behave exactly as REQ-022.

Structure
REQ-032 The state encoding typedef, the winner codes and the round-reset length constant (2) SHALL live in the shared package pong_pkg.
REQ-033 The win/deuce decision logic SHALL be one combinational sub-module, score_rules, that takes both scores and returns next scores, win and winner.

Verification
REQ-034 After reset, pulse goal_p1 high for 10 cycles -> score_p1=1, freeze=1 for 120 cycles, then round_rst=1 for 2 cycles, serve_dir=1.
REQ-035 Hold goal_p2 high through HOLD and ROUND_RST into ARM -> score_p2 increments only once and PLAY is not entered until goal_p2 falls.
REQ-036 Assert goal_p1 and goal_p2 in the same cycle -> scores unchanged and HOLD entered.
REQ-037 Without deuce, drive p1 to 7 -> OVER, winner=01, game_over=1, round_rst held; then new_game=1 -> scores 0 and ROUND_RST.
REQ-038 With SCORE_KEEPER_DEUCE_EN, from 7-6 let p2 score -> 6-6; from 8-6 -> winner=01.
REQ-039 Drop rst_n low mid-HOLD at 3-2 -> all outputs at their reset values, round_rst=1 for 2 cycles.
